if_stage: RTL and testbench

Instruction-fetch stage of the RISC-V pipeline. It owns the fetch PC, issues in-order word requests to instruction memory, and buffers up to two returned instructions. It presents one `{PC, inst}` pair per cycle to the fetch/decode pipeline register. Control-transfer redirects from later stages flush its buffer and discard stale memory responses.

---
 rtl/if_stage.sv | 150 +++++++++++++++
 tb/tb_if_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order word requests, buffers up to
// two returned instructions and presents one {PC, inst} pair per cycle to decode.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPC,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic [31:0] PC,
    output logic [31:0] inst,
    output logic        instWrite
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Fetch address and credit bookkeeping.
    logic [31:0] fetch_pc_q,   fetch_pc_d;
    logic [1:0]  inflight_q,   inflight_d;
    logic [1:0]  drop_cnt_q,   drop_cnt_d;

    // PCs of granted-but-unreturned requests, in grant order.
    logic [31:0] pcq_q [2];
    logic        pcq_wr_q,     pcq_wr_d;
    logic        pcq_rd_q,     pcq_rd_d;

    // Response buffer of {pc, inst} pairs.
    logic [31:0] fifo_pc_q   [2];
    logic [31:0] fifo_inst_q [2];
    logic        fifo_wr_q,    fifo_wr_d;
    logic        fifo_rd_q,    fifo_rd_d;
    logic [1:0]  fifo_count_q, fifo_count_d;

    // Fetch/decode output register.
    logic [31:0] pc_q,         pc_d;
    logic [31:0] inst_q,       inst_d;
    logic        inst_write_q, inst_write_d;

    logic        rsp_valid;
    logic        discard_now;
    logic        push;
    logic        pop;
    logic        grant;
    logic [2:0]  credit_used;

    // A response with nothing outstanding is a protocol error and is simply ignored.
    assign rsp_valid   = imemRvalid & (inflight_q != 2'd0);
    assign discard_now = rsp_valid & (drop_cnt_q != 2'd0);
    assign push        = rsp_valid & ~discard_now & ~redirect;
    assign pop         = (fifo_count_q != 2'd0) & ~stall & ~redirect;

    // Slots freed this cycle by a pop or a discard may be reused immediately.
    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count_q}
                       - {2'b00, pop} - {2'b00, discard_now};

    assign imemReq  = RSTN & ~redirect & (credit_used < 3'd2);
    assign imemAddr = fetch_pc_q;
    assign grant    = imemReq & imemGnt;

    assign PC        = pc_q;
    assign inst      = inst_q;
    assign instWrite = inst_write_q;

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        inflight_d   = inflight_q + {1'b0, grant} - {1'b0, rsp_valid};
        drop_cnt_d   = drop_cnt_q - {1'b0, discard_now};
        pcq_wr_d     = pcq_wr_q ^ grant;
        pcq_rd_d     = pcq_rd_q ^ rsp_valid;
        fifo_wr_d    = fifo_wr_q ^ push;
        fifo_rd_d    = fifo_rd_q ^ pop;
        fifo_count_d = fifo_count_q + {1'b0, push} - {1'b0, pop};

        if (redirect) begin
            // Everything still in flight is stale, except a response landing right now,
            // which is dropped on the spot.
            fetch_pc_d   = redirectPC & 32'hFFFF_FFFC;
            drop_cnt_d   = inflight_q - {1'b0, rsp_valid};
            fifo_wr_d    = 1'b0;
            fifo_rd_d    = 1'b0;
            fifo_count_d = 2'd0;
        end else if (grant) begin
            fetch_pc_d   = fetch_pc_q + 32'd4;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_write_d = inst_write_q;

        if (redirect) begin
            inst_d       = NOP;
            inst_write_d = 1'b0;
        end else if (pop) begin
            pc_d         = fifo_pc_q[fifo_rd_q];
            inst_d       = fifo_inst_q[fifo_rd_q];
            inst_write_d = 1'b1;
        end else if (!stall) begin
            inst_d       = NOP;
            inst_write_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            fetch_pc_q   <= RESET_PC;
            inflight_q   <= 2'd0;
            drop_cnt_q   <= 2'd0;
            pcq_wr_q     <= 1'b0;
            pcq_rd_q     <= 1'b0;
            fifo_wr_q    <= 1'b0;
            fifo_rd_q    <= 1'b0;
            fifo_count_q <= 2'd0;
            pc_q         <= 32'd0;
            inst_q       <= NOP;
            inst_write_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            inflight_q   <= inflight_d;
            drop_cnt_q   <= drop_cnt_d;
            pcq_wr_q     <= pcq_wr_d;
            pcq_rd_q     <= pcq_rd_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_rd_q    <= fifo_rd_d;
            fifo_count_q <= fifo_count_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_write_q <= inst_write_d;
        end
    end

    // Payload storage needs no reset; pointers and counts qualify every entry.
    always_ff @(posedge CLK) begin
        if (grant) begin
            pcq_q[pcq_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            fifo_pc_q[fifo_wr_q]   <= pcq_q[pcq_rd_q];
            fifo_inst_q[fifo_wr_q] <= imemRdata;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: cycle-exact vector table for the startup/stall stream, directed redirect
// sequences, and a randomized run scored against a reference PC stream.
module tb_if_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPC = 32'd0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt = 1'b0;
    logic        imemRvalid = 1'b0;
    logic [31:0] imemRdata = 32'd0;
    logic [31:0] PC;
    logic [31:0] inst;
    logic        instWrite;

    // Second instance starting near the top of the address space, fed by a 1-cycle memory.
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic [31:0] w_pc;
    logic [31:0] w_inst;
    logic        w_wr;

    always #5 CLK = ~CLK;

    if_stage dut (
        .CLK(CLK), .RSTN(RSTN), .stall(stall), .redirect(redirect), .redirectPC(redirectPC),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt),
        .imemRvalid(imemRvalid), .imemRdata(imemRdata),
        .PC(PC), .inst(inst), .instWrite(instWrite)
    );

    if_stage #(.RESET_PC(WRAP_PC)) dut_w (
        .CLK(CLK), .RSTN(RSTN), .stall(1'b0), .redirect(1'b0), .redirectPC(32'd0),
        .imemReq(w_req), .imemAddr(w_addr), .imemGnt(1'b1),
        .imemRvalid(w_rvalid), .imemRdata(w_rdata),
        .PC(w_pc), .inst(w_inst), .instWrite(w_wr)
    );

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            w_rvalid <= 1'b0;
            w_rdata  <= 32'd0;
        end else begin
            w_rvalid <= w_req;
            w_rdata  <= w_addr;
        end
    end

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } pend_t;

    typedef struct {
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_wr;
        logic [31:0] exp_pc;
    } vec_t;

    pend_t       pend_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_next;
    vec_t        tbl[15];

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          last_ready = -1;
    int          lat_min = 1;
    int          lat_max = 1;
    int          n_out = 0;
    bit          gnt_rand = 1'b0;
    logic [31:0] data_xor = 32'd0;
    logic        prev_stall = 1'b0;
    logic        prev_redirect = 1'b0;
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_inst = NOP;
    logic        m_wr = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void fill();
        while (exp_q.size() < 16) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 32'd4;
        end
    endfunction

    // Compares the output register against the reference stream at the start of a cycle.
    task automatic monitor();
        logic [31:0] e;
        if (prev_redirect) begin
            chk1("redir_bubble_wr", instWrite, 1'b0);
            chk("redir_bubble_inst", inst, NOP);
            chk("redir_pc_hold", PC, m_pc);
            m_wr   = 1'b0;
            m_inst = NOP;
        end else if (prev_stall) begin
            chk1("stall_hold_wr", instWrite, m_wr);
            chk("stall_hold_pc", PC, m_pc);
            chk("stall_hold_inst", inst, m_inst);
        end else if (instWrite) begin
            e = exp_q.pop_front();
            chk("out_pc", PC, e);
            chk("out_inst", inst, e ^ data_xor);
            m_pc   = e;
            m_inst = e ^ data_xor;
            m_wr   = 1'b1;
            n_out++;
            fill();
        end else begin
            chk("bubble_inst", inst, NOP);
            chk("bubble_pc_hold", PC, m_pc);
            m_wr   = 1'b0;
            m_inst = NOP;
        end
    endtask

    // Drives one cycle from a negedge, runs the memory model, and returns the request seen.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                        output logic req_o, output logic [31:0] addr_o);
        int rdy;
        stall      = st;
        redirect   = rd;
        redirectPC = rpc;
        imemGnt    = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
            imemRvalid = 1'b1;
            imemRdata  = pend_q[0].addr ^ data_xor;
        end else begin
            imemRvalid = 1'b0;
            imemRdata  = $urandom;
        end
        #1;
        req_o  = imemReq;
        addr_o = imemAddr;
        if (rd) chk1("req_low_on_redirect", imemReq, 1'b0);
        if (imemRvalid) void'(pend_q.pop_front());
        if (imemReq && imemGnt) begin
            rdy = cyc + $urandom_range(lat_min, lat_max);
            if (rdy <= last_ready) rdy = last_ready + 1;
            last_ready = rdy;
            pend_q.push_back('{imemAddr, rdy});
        end
        chk1("outstanding_le_2", pend_q.size() <= 2, 1'b1);
        if (rd) begin
            exp_q.delete();
            exp_next = rpc & 32'hFFFF_FFFC;
            fill();
        end
        prev_stall    = st;
        prev_redirect = rd;
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
        monitor();
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        RSTN       = 1'b0;
        stall      = 1'b0;
        redirect   = 1'b0;
        redirectPC = 32'd0;
        imemGnt    = 1'b0;
        imemRvalid = 1'b0;
        imemRdata  = 32'd0;
        pend_q.delete();
        last_ready = -1;
        @(negedge CLK);
        @(negedge CLK);
        chk1("rst_req", imemReq, 1'b0);
        chk("rst_addr", imemAddr, start_pc);
        chk("rst_pc", PC, 32'd0);
        chk("rst_inst", inst, NOP);
        chk1("rst_wr", instWrite, 1'b0);
        chk1("rst_w_req", w_req, 1'b0);
        chk("rst_w_addr", w_addr, WRAP_PC);
        RSTN          = 1'b1;
        cyc           = 0;
        prev_stall    = 1'b0;
        prev_redirect = 1'b0;
        m_pc          = 32'd0;
        m_inst        = NOP;
        m_wr          = 1'b0;
        exp_q.delete();
        exp_next      = start_pc;
        fill();
    endtask

    // Steps with no stall until a new instruction is presented, then checks its PC.
    task automatic wait_out(input string name, input logic [31:0] exp_pc);
        logic        r;
        logic [31:0] a;
        bit          got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1'b0, 1'b0, 32'd0, r, a);
            if (instWrite) got = 1'b1;
        end
        if (got) chk(name, PC, exp_pc);
        else chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        logic        r;
        logic [31:0] a;
        logic [31:0] wexp;

        // cycle: stall, req, addr, instWrite, PC  (1-cycle memory, data = address)
        tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b0, 32'h00};
        tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
        tbl[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h04};
        tbl[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h08};
        tbl[6]  = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h0C};
        tbl[7]  = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h0C};
        tbl[8]  = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h0C};
        tbl[9]  = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h0C};
        tbl[10] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h0C};
        tbl[11] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
        tbl[12] = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h14};
        tbl[13] = '{1'b0, 1'b1, 32'h24, 1'b1, 32'h18};
        tbl[14] = '{1'b0, 1'b1, 32'h28, 1'b1, 32'h1C};

        // Startup stream, 4-cycle stall, and the wrapping instance in parallel.
        data_xor = 32'd0; lat_min = 1; lat_max = 1; gnt_rand = 1'b0;
        do_reset(32'd0);
        for (int k = 0; k < 15; k++) begin
            chk1("tbl_wr", instWrite, tbl[k].exp_wr);
            chk("tbl_pc", PC, tbl[k].exp_pc);
            chk("tbl_inst", inst, tbl[k].exp_wr ? tbl[k].exp_pc : NOP);
            if (k >= 3 && k <= 6) begin
                wexp = WRAP_PC + 32'(4 * (k - 3));
                chk1("wrap_wr", w_wr, 1'b1);
                chk("wrap_pc", w_pc, wexp);
                chk("wrap_inst", w_inst, wexp);
            end
            step(tbl[k].stall, 1'b0, 32'd0, r, a);
            chk1("tbl_req", r, tbl[k].exp_req);
            chk("tbl_addr", a, tbl[k].exp_addr);
        end

        // Redirect to 0x100 with two requests outstanding on a 2-cycle memory.
        data_xor = 32'h1234_0000; lat_min = 2; lat_max = 2;
        do_reset(32'd0);
        for (int i = 0; i < 10 && pend_q.size() < 2; i++) step(1'b0, 1'b0, 32'd0, r, a);
        chk1("two_in_flight", pend_q.size() == 2, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0100, r, a);
        wait_out("redir_first_pc", 32'h0000_0100);
        wait_out("redir_second_pc", 32'h0000_0104);

        // Redirect coinciding with a response and a stall.
        data_xor = 32'h0BAD_0000; lat_min = 1; lat_max = 1;
        do_reset(32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, r, a);
        for (int i = 0; i < 10 && !(pend_q.size() > 0 && pend_q[0].ready <= cyc); i++)
            step(1'b0, 1'b0, 32'd0, r, a);
        step(1'b1, 1'b1, 32'h0000_0203, r, a);
        chk1("rs_bubble_wr", instWrite, 1'b0);
        chk("rs_bubble_inst", inst, NOP);
        step(1'b0, 1'b0, 32'd0, r, a);
        chk1("rs_refetch_req", r, 1'b1);
        chk("rs_refetch_addr", a, 32'h0000_0200);
        wait_out("rs_first_pc", 32'h0000_0200);

        // Random grants, latencies, stalls and redirects.
        data_xor = 32'hA5A5_0000; lat_min = 1; lat_max = 4; gnt_rand = 1'b1;
        do_reset(32'd0);
        n_out = 0;
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, $urandom, r, a);
        end
        chk1("random_progress", n_out >= 50, 1'b1);

        // Reset in the middle of traffic clears everything at once.
        do_reset(32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_checks);
        $fatal(1);
    end

endmodule
